// File: rtl/rat_recovery_ctrl_if.sv
// -----------------------------------------------------------------------------
// rat_recovery_ctrl_if
//   Bundles the squash/recovery signals between the ROB, the retirement RAT,
//   the speculative RAT write ports and the free list.
//
//   master : environment side (ROB + retirement RAT drive, consumers listen)
//   slave  : rat_recovery_ctrl side
//
//   squash_req       ROB head squashing (level)
//   rrat_preg        committed mapping, entry a at [a*PREG_W +: PREG_W]
//   dispatch_stall   blocks rename/dispatch
//   recovering       recovery sequence in progress
//   rat_wr_en        per-way RAT write enable
//   rat_wr_areg      per-way architectural index
//   rat_wr_preg      per-way physical tag (RAT sets ready on these writes)
//   fl_rebuild_valid one-cycle free-list reload strobe
//   fl_used_mask     physical registers mapped in the snapshot
//   recovery_done    one-cycle completion pulse
// -----------------------------------------------------------------------------
interface rat_recovery_ctrl_if #(
    parameter int AREG_NUM  = 32,
    parameter int PREG_NUM  = 64,
    parameter int COPY_WAYS = 4,
    parameter int AREG_W    = $clog2(AREG_NUM),
    parameter int PREG_W    = $clog2(PREG_NUM)
);
    logic                          squash_req;
    logic [AREG_NUM*PREG_W-1:0]    rrat_preg;
    logic                          dispatch_stall;
    logic                          recovering;
    logic [COPY_WAYS-1:0]          rat_wr_en;
    logic [COPY_WAYS*AREG_W-1:0]   rat_wr_areg;
    logic [COPY_WAYS*PREG_W-1:0]   rat_wr_preg;
    logic                          fl_rebuild_valid;
    logic [PREG_NUM-1:0]           fl_used_mask;
    logic                          recovery_done;

    modport master (
        output squash_req, rrat_preg,
        input  dispatch_stall, recovering, rat_wr_en, rat_wr_areg, rat_wr_preg,
               fl_rebuild_valid, fl_used_mask, recovery_done
    );

    modport slave (
        input  squash_req, rrat_preg,
        output dispatch_stall, recovering, rat_wr_en, rat_wr_areg, rat_wr_preg,
               fl_rebuild_valid, fl_used_mask, recovery_done
    );
endinterface

// File: rtl/rat_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// rat_recovery_ctrl
//   Sequences mispredict/exception recovery of the speculative RAT from the
//   retirement RAT. On an accepted squash the committed mapping is captured
//   into a snapshot, copied into the speculative RAT COPY_WAYS entries per
//   cycle, then a one-cycle free-list rebuild mask and a done pulse follow.
//   Dispatch is held stalled for the entire sequence.
//
//   clock  : system clock, all state on the rising edge
//   reset  : asynchronous, active-low
//   bus    : rat_recovery_ctrl_if.slave (squash input, RRAT input, RAT write
//            ports, free-list rebuild, status)
// -----------------------------------------------------------------------------
module rat_recovery_ctrl #(
    parameter int AREG_NUM  = 32,
    parameter int PREG_NUM  = 64,
    parameter int COPY_WAYS = 4,
    parameter int AREG_W    = $clog2(AREG_NUM),
    parameter int PREG_W    = $clog2(PREG_NUM)
) (
    input  logic               clock,
    input  logic               reset,
    rat_recovery_ctrl_if.slave bus
);
    localparam int COPY_CYC = AREG_NUM / COPY_WAYS;
    localparam int CNT_W    = (COPY_CYC > 1) ? $clog2(COPY_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COPY_CYC - 1);

    generate
        if ((AREG_NUM % COPY_WAYS) != 0) begin : g_bad_ways
            $error("rat_recovery_ctrl: AREG_NUM must be divisible by COPY_WAYS");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COPY     = 2'd1,
        ST_FLUSH_FL = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                        r_state;
    logic [CNT_W-1:0]              r_copy_cnt;
    logic [PREG_W-1:0]             r_snapshot [AREG_NUM];

    logic                          r_recovering;
    logic [COPY_WAYS-1:0]          r_rat_wr_en;
    logic [COPY_WAYS*AREG_W-1:0]   r_rat_wr_areg;
    logic [COPY_WAYS*PREG_W-1:0]   r_rat_wr_preg;
    logic                          r_fl_rebuild_valid;
    logic [PREG_NUM-1:0]           r_fl_used_mask;
    logic                          r_recovery_done;

    // Write-port contents for the first COPY cycle come straight from the
    // RRAT because the snapshot is being loaded on that same edge; later
    // cycles read the snapshot at the next group base.
    logic [AREG_W-1:0]             w_next_base;
    logic [COPY_WAYS*AREG_W-1:0]   w_first_areg;
    logic [COPY_WAYS*PREG_W-1:0]   w_first_preg;
    logic [COPY_WAYS*AREG_W-1:0]   w_step_areg;
    logic [COPY_WAYS*PREG_W-1:0]   w_step_preg;
    logic [PREG_NUM-1:0]           w_used_mask;

    // On the last COPY cycle this wraps; the result is never registered then.
    always_comb begin
        w_next_base = AREG_W'((int'(r_copy_cnt) + 1) * COPY_WAYS);
    end

    genvar gi;
    generate
        for (gi = 0; gi < COPY_WAYS; gi++) begin : g_way
            logic [AREG_W-1:0] w_step_idx;
            assign w_step_idx = w_next_base + AREG_W'(gi);
            assign w_first_areg[gi*AREG_W +: AREG_W] = AREG_W'(gi);
            assign w_first_preg[gi*PREG_W +: PREG_W] = bus.rrat_preg[gi*PREG_W +: PREG_W];
            assign w_step_areg[gi*AREG_W +: AREG_W]  = w_step_idx;
            assign w_step_preg[gi*PREG_W +: PREG_W]  = r_snapshot[w_step_idx];
        end
    endgenerate

    // Duplicate physical tags simply set the same bit.
    always_comb begin
        w_used_mask = '0;
        for (int a = 0; a < AREG_NUM; a++) begin
            w_used_mask[r_snapshot[a]] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state            <= ST_IDLE;
            r_copy_cnt         <= '0;
            for (int a = 0; a < AREG_NUM; a++) begin
                r_snapshot[a] <= '0;
            end
            r_recovering       <= 1'b0;
            r_rat_wr_en        <= '0;
            r_rat_wr_areg      <= '0;
            r_rat_wr_preg      <= '0;
            r_fl_rebuild_valid <= 1'b0;
            r_fl_used_mask     <= '0;
            r_recovery_done    <= 1'b0;
        end else begin
            r_fl_rebuild_valid <= 1'b0;
            r_recovery_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.squash_req) begin
                        for (int a = 0; a < AREG_NUM; a++) begin
                            r_snapshot[a] <= bus.rrat_preg[a*PREG_W +: PREG_W];
                        end
                        r_copy_cnt    <= '0;
                        r_state       <= ST_COPY;
                        r_recovering  <= 1'b1;
                        r_rat_wr_en   <= '1;
                        r_rat_wr_areg <= w_first_areg;
                        r_rat_wr_preg <= w_first_preg;
                    end
                end
                ST_COPY: begin
                    if (r_copy_cnt == CNT_LAST) begin
                        r_copy_cnt         <= '0;
                        r_state            <= ST_FLUSH_FL;
                        r_rat_wr_en        <= '0;
                        r_rat_wr_areg      <= '0;
                        r_rat_wr_preg      <= '0;
                        r_fl_rebuild_valid <= 1'b1;
                        r_fl_used_mask     <= w_used_mask;
                    end else begin
                        r_copy_cnt    <= r_copy_cnt + 1'b1;
                        r_rat_wr_areg <= w_step_areg;
                        r_rat_wr_preg <= w_step_preg;
                    end
                end
                ST_FLUSH_FL: begin
                    r_fl_used_mask  <= '0;
                    r_state         <= ST_DONE;
                    r_recovery_done <= 1'b1;
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_recovering <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_recovering <= 1'b0;
                end
            endcase
        end
    end

    // Stall also covers the squash cycle itself, before the FSM has moved.
    assign bus.dispatch_stall   = bus.squash_req | r_recovering;
    assign bus.recovering       = r_recovering;
    assign bus.rat_wr_en        = r_rat_wr_en;
    assign bus.rat_wr_areg      = r_rat_wr_areg;
    assign bus.rat_wr_preg      = r_rat_wr_preg;
    assign bus.fl_rebuild_valid = r_fl_rebuild_valid;
    assign bus.fl_used_mask     = r_fl_used_mask;
    assign bus.recovery_done    = r_recovery_done;

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rat_recovery_ctrl
//   Self-checking bench: a table of identity-squash vectors, hand-written
//   multi-cycle sequences, and randomized traffic compared against a
//   phase-counting behavioural model.
// -----------------------------------------------------------------------------
module tb_rat_recovery_ctrl;
    localparam int AREG_NUM  = 32;
    localparam int PREG_NUM  = 64;
    localparam int COPY_WAYS = 4;
    localparam int AREG_W    = $clog2(AREG_NUM);
    localparam int PREG_W    = $clog2(PREG_NUM);
    localparam int NCYC      = AREG_NUM / COPY_WAYS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rat_recovery_ctrl_if #(.AREG_NUM(AREG_NUM), .PREG_NUM(PREG_NUM), .COPY_WAYS(COPY_WAYS),
                           .AREG_W(AREG_W), .PREG_W(PREG_W)) bus();

    rat_recovery_ctrl #(.AREG_NUM(AREG_NUM), .PREG_NUM(PREG_NUM), .COPY_WAYS(COPY_WAYS),
                        .AREG_W(AREG_W), .PREG_W(PREG_W)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: phase 0 = idle, 1..NCYC = copy groups,
    // NCYC+1 = free-list rebuild, NCYC+2 = done.
    int                m_phase = 0;
    logic [PREG_W-1:0] m_snap [AREG_NUM];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (bus.squash_req) begin
                for (int a = 0; a < AREG_NUM; a++) m_snap[a] <= bus.rrat_preg[a*PREG_W +: PREG_W];
                m_phase <= 1;
            end
        end else if (m_phase == NCYC + 2) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [COPY_WAYS-1:0]        een;
        logic [COPY_WAYS*AREG_W-1:0] ea;
        logic [COPY_WAYS*PREG_W-1:0] ep;
        logic [PREG_NUM-1:0]         em;
        een = '0; ea = '0; ep = '0; em = '0;
        if (m_phase >= 1 && m_phase <= NCYC) begin
            een = '1;
            for (int w = 0; w < COPY_WAYS; w++) begin
                ea[w*AREG_W +: AREG_W] = AREG_W'((m_phase - 1) * COPY_WAYS + w);
                ep[w*PREG_W +: PREG_W] = m_snap[(m_phase - 1) * COPY_WAYS + w];
            end
        end
        if (m_phase == NCYC + 1) begin
            for (int a = 0; a < AREG_NUM; a++) em[m_snap[a]] = 1'b1;
        end
        cmp({tag, ".stall"}, 64'(bus.dispatch_stall), 64'(bus.squash_req | (m_phase != 0)));
        cmp({tag, ".recovering"}, 64'(bus.recovering), 64'(m_phase != 0));
        cmp({tag, ".wr_en"}, 64'(bus.rat_wr_en), 64'(een));
        cmp({tag, ".wr_areg"}, 64'(bus.rat_wr_areg), 64'(ea));
        cmp({tag, ".wr_preg"}, 64'(bus.rat_wr_preg), 64'(ep));
        cmp({tag, ".fl_valid"}, 64'(bus.fl_rebuild_valid), 64'(m_phase == NCYC + 1));
        cmp({tag, ".fl_mask"}, 64'(bus.fl_used_mask), 64'(em));
        cmp({tag, ".done"}, 64'(bus.recovery_done), 64'(m_phase == NCYC + 2));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_check(input string tag);
        tick();
        check_all(tag);
    endtask

    // kind 0: a -> (a+k) mod PREG_NUM; kind 1: all k; kind 2: random
    task automatic set_rrat(input int kind, input int k);
        logic [AREG_NUM*PREG_W-1:0] v;
        v = '0;
        for (int a = 0; a < AREG_NUM; a++) begin
            case (kind)
                0:       v[a*PREG_W +: PREG_W] = PREG_W'((a + k) % PREG_NUM);
                1:       v[a*PREG_W +: PREG_W] = PREG_W'(k);
                default: v[a*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, PREG_NUM - 1));
            endcase
        end
        bus.rrat_preg = v;
    endtask

    typedef struct {
        bit                  sq;
        bit                  stall;
        bit                  rec;
        int                  base;   // first areg written this cycle, -1 = no writes
        bit                  flv;
        logic [PREG_NUM-1:0] mask;
        bit                  done;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int first_b2b, second_b2b, done_cyc;
        bit stall_all, seen_end;
        logic [COPY_WAYS-1:0]        en;
        logic [COPY_WAYS*AREG_W-1:0] ea;
        logic [COPY_WAYS*PREG_W-1:0] ep;

        // Identity-squash vectors: row i is observed in cycle k+1+i.
        tbl[0] = '{sq: 1'b1, stall: 1'b1, rec: 1'b1, base: 0, flv: 1'b0, mask: '0, done: 1'b0};
        for (int i = 1; i < NCYC; i++)
            tbl[i] = '{sq: 1'b0, stall: 1'b1, rec: 1'b1, base: i * COPY_WAYS, flv: 1'b0, mask: '0, done: 1'b0};
        tbl[8]  = '{sq: 1'b0, stall: 1'b1, rec: 1'b1, base: -1, flv: 1'b1,
                    mask: 64'h0000_0000_FFFF_FFFF, done: 1'b0};
        tbl[9]  = '{sq: 1'b0, stall: 1'b1, rec: 1'b1, base: -1, flv: 1'b0, mask: '0, done: 1'b1};
        tbl[10] = '{sq: 1'b0, stall: 1'b0, rec: 1'b0, base: -1, flv: 1'b0, mask: '0, done: 1'b0};
        tbl[11] = '{sq: 1'b0, stall: 1'b0, rec: 1'b0, base: -1, flv: 1'b0, mask: '0, done: 1'b0};

        // ---- reset with random mapping ----
        bus.squash_req = 1'b0;
        set_rrat(2, 0);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_rrat(2, 0);
            tick_check("reset_hold");
        end
        cmp("reset.stall", 64'(bus.dispatch_stall), 64'd0);
        cmp("reset.mask", 64'(bus.fl_used_mask), 64'd0);
        rst_n = 1'b1;
        tick_check("reset_rel");
        tick_check("reset_rel");
        $display("seq reset: done");

        // ---- identity squash, table driven ----
        set_rrat(0, 0);
        bus.squash_req = 1'b1;
        #1;
        cmp("ident.stall_k", 64'(bus.dispatch_stall), 64'd1);
        cmp("ident.rec_k", 64'(bus.recovering), 64'd0);
        for (int i = 0; i < 12; i++) begin
            bus.squash_req = tbl[i].sq;
            tick();
            en = '0; ea = '0; ep = '0;
            if (tbl[i].base >= 0) begin
                en = '1;
                for (int w = 0; w < COPY_WAYS; w++) begin
                    ea[w*AREG_W +: AREG_W] = AREG_W'(tbl[i].base + w);
                    ep[w*PREG_W +: PREG_W] = PREG_W'(tbl[i].base + w);
                end
            end
            cmp("vec.stall", 64'(bus.dispatch_stall), 64'(tbl[i].stall));
            cmp("vec.recovering", 64'(bus.recovering), 64'(tbl[i].rec));
            cmp("vec.wr_en", 64'(bus.rat_wr_en), 64'(en));
            cmp("vec.wr_areg", 64'(bus.rat_wr_areg), 64'(ea));
            cmp("vec.wr_preg", 64'(bus.rat_wr_preg), 64'(ep));
            cmp("vec.fl_valid", 64'(bus.fl_rebuild_valid), 64'(tbl[i].flv));
            cmp("vec.fl_mask", 64'(bus.fl_used_mask), 64'(tbl[i].mask));
            cmp("vec.done", 64'(bus.recovery_done), 64'(tbl[i].done));
            $display("vec %0d: sq=%0d stall=%0d rec=%0d en=%h areg=%h", i, tbl[i].sq,
                     bus.dispatch_stall, bus.recovering, bus.rat_wr_en, bus.rat_wr_areg);
        end

        // ---- remapped squash ----
        set_rrat(0, 32);
        bus.squash_req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick_check("remap");
            bus.squash_req = 1'b0;
            if (c == 1) begin
                cmp("remap.w0_areg", 64'(bus.rat_wr_areg[AREG_W-1:0]), 64'd0);
                cmp("remap.w0_preg", 64'(bus.rat_wr_preg[PREG_W-1:0]), 64'd32);
            end
            if (c == NCYC + 1) cmp("remap.mask", 64'(bus.fl_used_mask), 64'hFFFF_FFFF_0000_0000);
        end
        $display("seq remap: done");

        // ---- snapshot isolation and ignored re-squash ----
        set_rrat(0, 7);
        done_cyc = -1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) bus.squash_req = 1'b1;
            if (c == 2) bus.squash_req = 1'b0;
            if (c == 3) set_rrat(1, 5);
            if (c == 5) bus.squash_req = 1'b1;
            if (c == 6) bus.squash_req = 1'b0;
            tick_check("ignore");
            if (c == 3) cmp("ignore.w0_preg", 64'(bus.rat_wr_preg[PREG_W-1:0]), 64'd15);
            if (bus.recovery_done === 1'b1) done_cyc = c;
        end
        cmp("ignore.done_cycle", 64'(done_cyc), 64'd10);
        cmp("ignore.no_restart", 64'(bus.recovering), 64'd0);
        $display("seq ignore: done_cycle=%0d", done_cyc);

        // ---- reset in the middle of COPY ----
        set_rrat(2, 0);
        bus.squash_req = 1'b1;
        tick_check("midrst");
        bus.squash_req = 1'b0;
        tick_check("midrst");
        tick_check("midrst");
        rst_n = 1'b0;
        #1;
        cmp("midrst.wr_en", 64'(bus.rat_wr_en), 64'd0);
        cmp("midrst.recovering", 64'(bus.recovering), 64'd0);
        cmp("midrst.stall", 64'(bus.dispatch_stall), 64'd0);
        tick_check("midrst_hold");
        rst_n = 1'b1;
        seen_end = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick_check("midrst_after");
            if (bus.fl_rebuild_valid === 1'b1 || bus.recovery_done === 1'b1) seen_end = 1'b1;
        end
        cmp("midrst.no_pulses", 64'(seen_end), 64'd0);
        $display("seq midrst: done");

        // ---- back-to-back with squash held high ----
        set_rrat(2, 0);
        bus.squash_req = 1'b1;
        first_b2b = -1; second_b2b = -1; stall_all = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            tick_check("b2b");
            if (bus.dispatch_stall !== 1'b1) stall_all = 1'b0;
            if (bus.rat_wr_en !== '0 && bus.rat_wr_areg[AREG_W-1:0] == '0) begin
                if (first_b2b < 0) first_b2b = c;
                else if (second_b2b < 0) second_b2b = c;
            end
        end
        cmp("b2b.first_copy", 64'(first_b2b), 64'd1);
        cmp("b2b.second_copy", 64'(second_b2b), 64'd12);
        cmp("b2b.stall_held", 64'(stall_all), 64'd1);
        bus.squash_req = 1'b0;
        for (int c = 0; c < 12; c++) tick_check("b2b_drain");
        $display("seq b2b: first=%0d second=%0d", first_b2b, second_b2b);

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 800; c++) begin
            bus.squash_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) set_rrat(2, 0);
            if ($urandom_range(0, 150) == 0) begin
                bus.squash_req = 1'b0;
                rst_n = 1'b0;
                tick_check("rnd_rst");
                rst_n = 1'b1;
            end else begin
                tick_check("rnd");
            end
        end
        $display("seq random: done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rat_recovery_ctrl.md
Name: rat_recovery_ctrl

Overview:
- Sequences branch-mispredict/exception recovery of the front-end rename state from the retirement RAT.
- On a squash, snapshots the committed architectural-to-physical mapping, then copies it into the speculative RAT COPY_WAYS entries per cycle.
- Then emits a one-cycle free-list rebuild mask and a done pulse.
- Holds dispatch stalled for the whole sequence. Sits between the ROB squash signal, the retirement RAT output, the RAT write ports and the free list.

Parameters:
- AREG_NUM, 32, number of architectural registers
- PREG_NUM, 64, number of physical registers
- COPY_WAYS, 4, RAT entries written per COPY cycle; AREG_NUM must be divisible by COPY_WAYS (elaboration-time check)
- AREG_W, $clog2(AREG_NUM), architectural index width
- PREG_W, $clog2(PREG_NUM), physical index width

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- squash_req  in  1  ROB head is squashing (mispredict/exception); level, sampled each edge
- rrat_preg  in  AREG_NUM*PREG_W  committed mapping, entry a at bits [a*PREG_W +: PREG_W]
- dispatch_stall  out  1  blocks rename/dispatch
- recovering  out  1  FSM not IDLE
- rat_wr_en  out  COPY_WAYS  per-way RAT write enable
- rat_wr_areg  out  COPY_WAYS*AREG_W  per-way architectural index
- rat_wr_preg  out  COPY_WAYS*PREG_W  per-way physical tag; RAT sets ready bit = 1 on these writes
- fl_rebuild_valid  out  1  one-cycle: free list reloads from fl_used_mask
- fl_used_mask  out  PREG_NUM  bit p = 1 iff p is mapped in the snapshot; free = ~mask
- recovery_done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, COPY, FLUSH_FL, DONE. Registers: state, copy_cnt (width $clog2(AREG_NUM/COPY_WAYS), min 1), snapshot[AREG_NUM].
- Reset (reset==0, asynchronous):
  - state = IDLE, copy_cnt = 0, snapshot all 0.
  - All outputs 0: dispatch_stall, recovering, rat_wr_en, rat_wr_areg, rat_wr_preg, fl_rebuild_valid, fl_used_mask, recovery_done.
  - Reset mid-sequence aborts immediately; no further RAT writes or pulses.
- IDLE:
  - If squash_req == 1 at an edge: snapshot <= rrat_preg, copy_cnt <= 0, go to COPY.
  - Otherwise stay.
- COPY:
  - Each cycle, way w writes areg = copy_cnt*COPY_WAYS + w with preg = snapshot[that areg]; rat_wr_en = all ones.
  - copy_cnt increments each cycle. After AREG_NUM/COPY_WAYS cycles (copy_cnt at max), go to FLUSH_FL.
- FLUSH_FL:
  - fl_rebuild_valid = 1 for exactly this cycle.
  - fl_used_mask = OR over all a of onehot(snapshot[a]); duplicate pregs set one bit.
  - fl_used_mask is 0 in every other state.
  - Next state DONE.
- DONE: recovery_done = 1 for exactly this cycle; next state IDLE.
- Output registering and timing:
  - All outputs except dispatch_stall are decoded from registered state only.
  - dispatch_stall = squash_req | (state != IDLE), so dispatch is blocked in the squash cycle itself.
  - recovering = (state != IDLE).
  - rat_wr_en = 0 outside COPY. rat_wr_areg and rat_wr_preg are 0 when rat_wr_en is 0.
- Latency, squash sampled at edge k with defaults:
  - COPY occupies cycles k+1..k+8.
  - FLUSH_FL at k+9, DONE at k+10.
  - IDLE at k+11; a new squash is accepted at edge k+11 at earliest.
  - Total length is AREG_NUM/COPY_WAYS + 2 cycles after acceptance.
- Boundary conditions:
  - squash_req high while not IDLE is ignored and not queued. The ROB never re-squashes during recovery without new retirement activity.
  - rrat_preg changes after acceptance are not reflected; the snapshot is used.
  - squash_req held high continuously restarts a new recovery each time IDLE is reached (back-to-back legal).
  - COPY_WAYS == AREG_NUM: single COPY cycle, copy_cnt stays 0.
  - copy_cnt wraps to 0 on the COPY -> FLUSH_FL transition.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-random inputs -> every output 0, recovering=0. Release, squash_req=0 -> outputs stay 0.
- Identity squash: rrat_preg[a]=a, one-cycle squash_req at edge k.
  - Cycle k+1: rat_wr_areg = {3,2,1,0}, rat_wr_preg = {3,2,1,0}, rat_wr_en = 4'b1111.
  - Cycle k+8: areg {31..28}.
  - k+9: fl_rebuild_valid=1, fl_used_mask = 64'h0000_0000_FFFF_FFFF.
  - k+10: recovery_done=1. k+11: recovering=0.
  - dispatch_stall high k..k+10.
- Remapped squash: rrat_preg[a]=a+32.
  - Way 0 in first COPY cycle writes areg 0 -> preg 32.
  - fl_used_mask = 64'hFFFF_FFFF_0000_0000.
- Snapshot/ignore:
  - Change rrat_preg to all 5 at k+2 -> writes still use the original mapping.
  - Pulse squash_req at k+4 -> no restart; done still at k+10.
- Reset mid-COPY: assert reset=0 at k+3 between edges -> rat_wr_en, recovering, dispatch_stall drop to 0 asynchronously. After release: no fl_rebuild_valid or recovery_done.
- Back-to-back: squash_req held high from k -> second recovery accepted at edge k+11, its first COPY write at k+12, dispatch_stall continuously high.
